// File: rtl/parking_pkg.sv
// Shared constants and FSM encoding for the parking-lot entry/exit paths.
package parking_pkg;
  localparam int NUM_SPOTS = 8;
  localparam int ID_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    ALLOC,
    GRANT,
    RELEASE
  } state_t;

  function automatic logic [ID_W:0] popcount(
    input logic [NUM_SPOTS-1:0] v
  );
    logic [ID_W:0] c;
    c = '0;
    for (int i = 0; i < NUM_SPOTS; i++) begin
      c = c + {{ID_W{1'b0}}, v[i]};
    end
    return c;
  endfunction
endpackage

// File: rtl/free_spot_encoder.sv
// Lowest-zero priority encoder: picks the lowest free spot index.
module free_spot_encoder
  import parking_pkg::*;
(
  input  logic [NUM_SPOTS-1:0] occupancy,
  output logic [ID_W-1:0]      index,
  output logic                 any_free
);
  always_comb begin
    index = '0;
    // Scan downward so the lowest free index wins.
    for (int i = NUM_SPOTS - 1; i >= 0; i--) begin
      if (!occupancy[i]) begin
        index = ID_W'(i);
      end
    end
  end

  assign any_free = ~&occupancy;
endmodule

// File: rtl/entry_parking_lot.sv
// Entry-gate allocator: grants lowest free spot, tracks exits and occupancy.
// Optional PARK_STATS_EN adds total_entries / total_rejects counters.
module entry_parking_lot
  import parking_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enter_req,
  output logic                 enter_ack,
  output logic [ID_W-1:0]      park_number,
  input  logic                 exit_valid,
  input  logic [ID_W-1:0]      exit_number,
  output logic                 exit_err,
  output logic [NUM_SPOTS-1:0] occupancy,
  output logic [ID_W:0]        free_count,
`ifdef PARK_STATS_EN
  output logic                 full,
  output logic [15:0]          total_entries,
  output logic [15:0]          total_rejects
`else
  output logic                 full
`endif
);
  state_t                 state_q;
  state_t                 state_d;
  logic [ID_W-1:0]        idx_q;
  logic [ID_W-1:0]        park_q;
  logic [NUM_SPOTS-1:0]   occ_q;
  logic [NUM_SPOTS-1:0]   occ_d;
  logic [NUM_SPOTS-1:0]   grant_set;
  logic [NUM_SPOTS-1:0]   exit_clr;
  logic                   exit_err_q;
  logic                   exit_hit;
  logic [ID_W-1:0]        enc_idx;
  logic                   any_free;

  free_spot_encoder u_enc (
    .occupancy (occ_q),
    .index     (enc_idx),
    .any_free  (any_free)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (enter_req && any_free) state_d = ALLOC;
      ALLOC:   state_d = GRANT;
      GRANT:   state_d = RELEASE;
      RELEASE: if (!enter_req) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign enter_ack   = (state_q == GRANT);
  assign park_number = enter_ack ? idx_q : park_q;
  assign exit_hit    = exit_valid && occ_q[exit_number];
  assign exit_clr    = exit_hit ? (NUM_SPOTS'(1) << exit_number) : '0;
  assign grant_set   = enter_ack ? (NUM_SPOTS'(1) << idx_q) : '0;
  assign occ_d       = (occ_q & ~exit_clr) | grant_set;

  assign occupancy  = occ_q;
  assign exit_err   = exit_err_q;
  assign full       = ~any_free;
  assign free_count = (ID_W + 1)'(NUM_SPOTS) - popcount(occ_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      park_q     <= '0;
      occ_q      <= '0;
      exit_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      occ_q      <= occ_d;
      exit_err_q <= exit_valid && !occ_q[exit_number];
      if (state_q == ALLOC) idx_q <= enc_idx;
      if (enter_ack) park_q <= idx_q;
    end
  end

`ifdef PARK_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      total_entries <= '0;
      total_rejects <= '0;
    end else begin
      if (enter_ack && total_entries != 16'hFFFF)
        total_entries <= total_entries + 16'd1;
      if (state_q == IDLE && enter_req && !any_free &&
          total_rejects != 16'hFFFF)
        total_rejects <= total_rejects + 16'd1;
    end
  end
`endif
endmodule
